// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int LAT_MAX = 7;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  // A request is legal when it is word aligned and falls inside the array.
  function automatic logic addr_legal(input logic [31:0] addr, input int aw);
    return (addr[1:0] == 2'b00) && ((addr >> (aw + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/dmem_write_buffer.sv
// One-entry posted write buffer: holds the last store, forwards it to a
// matching read and drains it into the array when the array port is free.
module dmem_write_buffer #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [AW-1:0] load_idx_i,
  input  logic [31:0]   load_data_i,
  input  logic          drain_block_i,
  input  logic [AW-1:0] lookup_idx_i,
  output logic          hit_o,
  output logic [31:0]   fwd_data_o,
  output logic          drain_en_o,
  output logic [AW-1:0] drain_idx_o,
  output logic [31:0]   drain_data_o
);

  logic          valid_q, valid_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   data_q, data_d;

  assign hit_o        = valid_q && (idx_q == lookup_idx_i);
  assign fwd_data_o   = data_q;
  assign drain_idx_o  = idx_q;
  assign drain_data_o = data_q;

  // Drain whenever the array port is not taken by a read capture; a new
  // store loads in the same edge the old entry leaves.
  always_comb begin
    drain_en_o = valid_q & ~drain_block_i;
    valid_d    = valid_q & ~drain_en_o;
    idx_d      = idx_q;
    data_d     = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      idx_d   = load_idx_i;
      data_d  = load_data_i;
    end
  end

  // Entry registers; a pending store is discarded by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory: word reads with LAT wait states (Stall back to the
// hazard unit), posted writes through a one-entry buffer with forwarding.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] DataAddr,
  input  logic [31:0] WriteMem,
  output logic [31:0] DataMemOut,
  output logic        Stall,
  output logic        AddrErr
);

  localparam int AW = $clog2(DEPTH);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rdata_q;
  logic [31:0]      mem_q [DEPTH];

  logic [AW-1:0] idx;
  logic          addr_ok;
  logic          illegal;
  logic          rd_cap;
  logic          wr_acc;
  logic          buf_hit;
  logic [31:0]   buf_data;
  logic          drain_en;
  logic [AW-1:0] drain_idx;
  logic [31:0]   drain_data;
  logic [31:0]   rd_value;

  assign idx     = DataAddr[AW+1:2];
  assign addr_ok = addr_legal(DataAddr, AW);
  // A simultaneous read and write is handled as an illegal read.
  assign illegal = ~addr_ok | (MemRead & MemWrite);
  assign rd_cap  = (state_q == IDLE) & MemRead;
  assign wr_acc  = MemWrite & ~MemRead & addr_ok;

  dmem_write_buffer #(
    .AW(AW)
  ) u_wbuf (
    .clk          (clk),
    .rst_n        (rst),
    .load_i       (wr_acc),
    .load_idx_i   (idx),
    .load_data_i  (WriteMem),
    .drain_block_i(rd_cap),
    .lookup_idx_i (idx),
    .hit_o        (buf_hit),
    .fwd_data_o   (buf_data),
    .drain_en_o   (drain_en),
    .drain_idx_o  (drain_idx),
    .drain_data_o (drain_data)
  );

  // Read value: zero for illegal requests, buffered store if it matches
  always_comb begin
    if (illegal) begin
      rd_value = '0;
    end else if (buf_hit) begin
      rd_value = buf_data;
    end else begin
      rd_value = mem_q[idx];
    end
  end

  // Outputs; all forced low while reset is held, even with MemRead high
  always_comb begin
    Stall      = 1'b0;
    DataMemOut = rdata_q;
    if ((LAT == 0) && rd_cap) begin
      DataMemOut = rd_value;
    end
    if (LAT != 0) begin
      Stall = rd_cap | (state_q == WAIT);
    end
    AddrErr = illegal & (rd_cap | (MemWrite & ~MemRead));
    if (!rst) begin
      Stall      = 1'b0;
      AddrErr    = 1'b0;
      DataMemOut = '0;
    end
  end

  // Read sequencer: capture in IDLE, count wait states, release in DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (MemRead) begin
            rdata_q <= rd_value;
            if (LAT == 1) begin
              state_q <= DONE;
            end else if (LAT >= 2) begin
              state_q <= WAIT;
              cnt_q   <= CNT_W'(1);
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(LAT - 1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Single write port, fed only by the buffer drain; contents survive reset
  always_ff @(posedge clk) begin
    if (drain_en) begin
      mem_q[drain_idx] <= drain_data;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LAT=2, 0, 3) driven one at a
// time, checked every cycle against a word-level memory model.
module tb_dmem_responder;

  localparam int NI    = 3;
  localparam int DEPTH = 1024;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 0 : 3);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v   [NI];
  logic        rd_v    [NI];
  logic        wr_v    [NI];
  logic [31:0] addr_v  [NI];
  logic [31:0] wdat_v  [NI];
  logic [31:0] dout_v  [NI];
  logic        stall_v [NI];
  logic        err_v   [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int L = (gi == 0) ? 2 : ((gi == 1) ? 0 : 3);
    dmem_responder #(
      .DEPTH(DEPTH),
      .LAT  (L)
    ) u_dut (
      .clk       (clk),
      .rst       (rst_v[gi]),
      .MemRead   (rd_v[gi]),
      .MemWrite  (wr_v[gi]),
      .DataAddr  (addr_v[gi]),
      .WriteMem  (wdat_v[gi]),
      .DataMemOut(dout_v[gi]),
      .Stall     (stall_v[gi]),
      .AddrErr   (err_v[gi])
    );
  end

  // expectations for the current cycle
  bit          exp_stall [NI];
  bit          exp_err   [NI];
  bit          exp_chk   [NI];
  logic [31:0] exp_data  [NI];
  bit          chk_en = 1'b0;
  bit          pin_en = 1'b0;
  string       pin_name;
  logic [31:0] pin_got, pin_want;

  int checks   = 0;
  int failures = 0;

  // model: committed words plus the one pending store per instance
  logic [31:0] m_mem   [NI][DEPTH];
  bit          m_known [NI][DEPTH];
  bit          m_pv    [NI];
  int          m_pi    [NI];
  logic [31:0] m_pd    [NI];

  function automatic bit addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:12] == 20'd0);
  endfunction

  // single compare process
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (stall_v[k] !== exp_stall[k]) begin
          failures++;
          $display("FAIL stall inst=%0d t=%0t got=%b want=%b", k, $time, stall_v[k], exp_stall[k]);
        end
        checks++;
        if (err_v[k] !== exp_err[k]) begin
          failures++;
          $display("FAIL addrerr inst=%0d t=%0t got=%b want=%b", k, $time, err_v[k], exp_err[k]);
        end
        if (exp_chk[k]) begin
          checks++;
          if (dout_v[k] !== exp_data[k]) begin
            failures++;
            $display("FAIL dataout inst=%0d t=%0t got=%08h want=%08h", k, $time, dout_v[k], exp_data[k]);
          end
        end
      end
      if (pin_en) begin
        checks++;
        if (pin_got !== pin_want) begin
          failures++;
          $display("FAIL %s t=%0t got=%08h want=%08h", pin_name, $time, pin_got, pin_want);
        end
      end
    end
  end

  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] want);
    pin_name = name;
    pin_got  = got;
    pin_want = want;
    pin_en   = 1'b1;
  endtask

  task automatic clear_all();
    for (int j = 0; j < NI; j++) begin
      rst_v[j]     = 1'b1;
      rd_v[j]      = 1'b0;
      wr_v[j]      = 1'b0;
      addr_v[j]    = '0;
      wdat_v[j]    = '0;
      exp_stall[j] = 1'b0;
      exp_err[j]   = 1'b0;
      exp_chk[j]   = 1'b0;
      exp_data[j]  = '0;
    end
  endtask

  task automatic drain_except(input int k, input bit blocked);
    for (int j = 0; j < NI; j++) begin
      if (m_pv[j] && !(blocked && j == k)) begin
        m_mem[j][m_pi[j]]   = m_pd[j];
        m_known[j][m_pi[j]] = 1'b1;
        m_pv[j]             = 1'b0;
      end
    end
  endtask

  // one clock cycle on instance k, other instances idle
  task automatic cycle(input int k, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input bit es, input bit ee, input bit cd,
                       input logic [31:0] ed, input bit cap);
    clear_all();
    rd_v[k] = rd; wr_v[k] = wr; addr_v[k] = a; wdat_v[k] = d;
    exp_stall[k] = es; exp_err[k] = ee; exp_chk[k] = cd; exp_data[k] = ed;
    @(posedge clk);
    drain_except(k, cap);
    if (wr && !rd && addr_ok(a)) begin
      m_pv[k] = 1'b1;
      m_pi[k] = int'(a[11:2]);
      m_pd[k] = d;
    end
    #1;
    pin_en = 1'b0;
  endtask

  task automatic reset_cycle(input int k, input bit hold_rd, input logic [31:0] a);
    clear_all();
    rst_v[k] = 1'b0; rd_v[k] = hold_rd; addr_v[k] = a;
    exp_chk[k] = 1'b1; exp_data[k] = '0;
    $display("txn inst=%0d RESET hold_rd=%0d addr=%08h", k, hold_rd, a);
    @(posedge clk);
    m_pv[k] = 1'b0;
    drain_except(k, 1'b1);
    #1;
    pin_en = 1'b0;
  endtask

  task automatic wr_txn(input int k, input logic [31:0] a, input logic [31:0] d);
    bit lg;
    lg = addr_ok(a);
    $display("txn inst=%0d WR addr=%08h data=%08h err=%0d", k, a, d, !lg);
    cycle(k, 1'b0, 1'b1, a, d, 1'b0, !lg, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) cycle(k, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // read spanning LAT+1 cycles; abort_at >= 0 asserts reset in that cycle
  task automatic rd_txn(input int k, input logic [31:0] a, input bit also_wr,
                        input bit use_lit, input logic [31:0] lit, input int abort_at);
    int          lat;
    bit          lg;
    bit          known;
    int          ix;
    logic [31:0] v;
    lat = lat_of(k);
    lg  = addr_ok(a) && !also_wr;
    ix  = int'(a[11:2]);
    if (!lg) begin
      v = '0; known = 1'b1;
    end else if (m_pv[k] && m_pi[k] == ix) begin
      v = m_pd[k]; known = 1'b1;
    end else begin
      v = m_mem[k][ix]; known = m_known[k][ix];
    end
    $display("txn inst=%0d RD addr=%08h wr=%0d exp=%08h known=%0d err=%0d", k, a, also_wr, v, known, !lg);
    if (use_lit) pin("model_pin", v, lit);
    for (int c = 0; c <= lat; c++) begin
      if (c == abort_at) begin
        reset_cycle(k, 1'b1, a);
        return;
      end
      cycle(k, 1'b1, also_wr && (c == 0), a, 32'h0, c < lat, (c == 0) && !lg,
            (c == lat) && known, use_lit ? lit : v, c == 0);
    end
  endtask

  task automatic rand_addr(output logic [31:0] a);
    int r, ix;
    r  = int'($urandom_range(0, 19));
    ix = int'($urandom_range(0, 15));
    if (r == 0)      a = 32'(ix * 4) + 32'($urandom_range(1, 3));
    else if (r == 1) a = 32'h0000_1000 + 32'(ix * 4);
    else if (r == 2) a = 32'h8000_0000 | 32'(ix * 4);
    else             a = 32'(ix * 4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int p;
    for (int k = 0; k < NI; k++) begin
      m_pv[k] = 1'b0; m_pi[k] = 0; m_pd[k] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[k][i] = '0; m_known[k][i] = 1'b0;
      end
    end
    clear_all();
    #2;
    // power-on reset: outputs must be zero
    for (int j = 0; j < NI; j++) begin
      rst_v[j] = 1'b0; exp_chk[j] = 1'b1; exp_data[j] = '0;
    end
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end

    // LAT=2 directed
    wr_txn(0, 32'h10, 32'hDEADBEEF);
    idle(0, 3);
    rd_txn(0, 32'h10, 1'b0, 1'b1, 32'hDEADBEEF, -1);
    wr_txn(0, 32'h20, 32'h11111111);
    rd_txn(0, 32'h20, 1'b0, 1'b1, 32'h11111111, -1);
    idle(0, 1);
    reset_cycle(0, 1'b0, 32'h0);
    rd_txn(0, 32'h20, 1'b0, 1'b1, 32'h11111111, -1);
    rd_txn(0, 32'h13, 1'b0, 1'b1, 32'h0, -1);
    wr_txn(0, 32'h0, 32'hCAFEF00D);
    idle(0, 1);
    wr_txn(0, 32'h1000, 32'h0BADBAD0);
    rd_txn(0, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D, -1);
    wr_txn(0, 32'h30, 32'hAAAA5555);
    idle(0, 2);
    wr_txn(0, 32'h30, 32'h12345678);
    rd_txn(0, 32'h30, 1'b0, 1'b1, 32'h12345678, 1);
    rd_txn(0, 32'h30, 1'b0, 1'b1, 32'hAAAA5555, -1);
    rd_txn(0, 32'h40, 1'b1, 1'b1, 32'h0, -1);

    // LAT=0 directed
    wr_txn(1, 32'h0, 32'h01234567);
    wr_txn(1, 32'h4, 32'h89ABCDEF);
    rd_txn(1, 32'h4, 1'b0, 1'b1, 32'h89ABCDEF, -1);
    rd_txn(1, 32'h0, 1'b0, 1'b1, 32'h01234567, -1);
    rd_txn(1, 32'h13, 1'b0, 1'b1, 32'h0, -1);

    // LAT=3 back-to-back reads
    wr_txn(2, 32'h0, 32'hA0A0A0A0);
    wr_txn(2, 32'h4, 32'hA1A1A1A1);
    wr_txn(2, 32'h8, 32'hA2A2A2A2);
    idle(2, 1);
    rd_txn(2, 32'h0, 1'b0, 1'b1, 32'hA0A0A0A0, -1);
    rd_txn(2, 32'h4, 1'b0, 1'b1, 32'hA1A1A1A1, -1);
    rd_txn(2, 32'h8, 1'b0, 1'b1, 32'hA2A2A2A2, -1);

    // randomized traffic per instance
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 16; i++) wr_txn(k, 32'(i * 4), $urandom);
      idle(k, 1);
      for (int n = 0; n < 150; n++) begin
        p = int'($urandom_range(0, 99));
        rand_addr(a);
        if (p < 40)      rd_txn(k, a, 1'b0, 1'b0, 32'h0, -1);
        else if (p < 45) rd_txn(k, a, 1'b1, 1'b0, 32'h0, -1);
        else if (p < 80) wr_txn(k, a, $urandom);
        else if (p < 97) idle(k, 1);
        else             reset_cycle(k, 1'b0, 32'h0);
      end
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the MEM stage of the pipelined MIPS core. It accepts the core's word read and write requests (DataAddr, WriteMem, MMemRead, MMemWrite) and returns DataMemOut. Reads take a parameterised number of wait states and assert a Stall back to the hazard logic. Writes are posted through a one-entry write buffer, with read-after-write forwarding.

## Interface
- DEPTH, 1024, number of 32-bit words in the array (power of two); AW = log2(DEPTH)
- LAT, 2, read wait states (0..7); 0 = combinational read, no stall
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- MemRead  input  1  read request, held stable by the core while Stall=1
- MemWrite  input  1  write request, single-cycle
- DataAddr  input  32  byte address; word index = DataAddr[AW+1:2]
- WriteMem  input  32  store data
- DataMemOut  output  32  read data, valid in the cycle Stall falls (or the request cycle if LAT=0)
- Stall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM while high
- AddrErr  output  1  one-cycle pulse on a misaligned, out-of-range or illegal request

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE, MemRead=1 and address legal:
  - capture read data into rdata: write-buffer data if the buffer is valid with a matching index, else array[index]
  - LAT=0: DataMemOut = captured value combinationally, Stall=0, stay in IDLE
  - LAT=1: Stall=1, go to DONE
  - LAT≥2: Stall=1, cnt←1, go to WAIT
- WAIT: Stall=1; cnt increments; when cnt==LAT-1, go to DONE.
- DONE: Stall=0, DataMemOut=rdata; go to IDLE unconditionally. The held MemRead is consumed here and not re-issued.
- Write (MemWrite=1, legal, MemRead=0):
  - load the buffer {valid, index, data}; never stalls
  - if the buffer is already valid, the old entry drains to the array at the same edge the new entry loads
- Drain: the buffer writes the array at any edge where it is valid, except in an IDLE read-capture cycle. The array is a single port.
- Illegal requests (DataAddr[1:0]≠0, DataAddr[31:AW+2]≠0, or MemRead&MemWrite):
  - AddrErr=1 for that cycle
  - write dropped
  - read returns 0 with normal latency
  - MemRead&MemWrite is treated as a read
- DataMemOut holds rdata in all non-LAT=0 cycles. It is only meaningful in DONE.

## Timing
- Read latency: Stall high for exactly LAT cycles starting in the request cycle; data is valid in cycle LAT and captured by MEM/WB at the end of that cycle.
- Back-to-back reads: DONE→IDLE adds no bubble. The next request is evaluated the cycle after DONE.
- Write: posted. The array is updated at the first permitted edge after the request cycle. A read in the following cycle hits the buffer and returns the new data.
- Reset (rst low, any state):
  - FSM←IDLE, cnt←0, rdata←0, buffer valid←0 (a pending write is lost)
  - Stall=0, AddrErr=0, DataMemOut=0
  - array contents undefined, not cleared
- Reset released during a held MemRead: a fresh read starts in the first cycle after release.

## Structure
- Package dmem_pkg: state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2), LAT_MAX=7, and the address-legality check function.
- Sub-module dmem_write_buffer: entry registers, match compare, forward mux and drain enable.
- The FSM, cnt, rdata and array stay in dmem_responder.

## Test plan
- LAT=2: write 0xDEADBEEF to 0x10, idle 3 cycles, read 0x10 → Stall high 2 cycles, DataMemOut=0xDEADBEEF in cycle 2, AddrErr=0.
- LAT=2: write 0x11111111 to 0x20, then read 0x20 in the next cycle → forwarded 0x11111111; array[8]=0x11111111 after DONE.
- LAT=0: writes to 0x0 and 0x4 back-to-back, then reads of 0x4 and 0x0 → 0 stall cycles, data returned the same cycle, both words correct.
- Illegal requests:
  - read 0x13 → AddrErr pulse, DataMemOut=0 after the LAT stall
  - write to 0x1000 with DEPTH=1024 → AddrErr, array unchanged
- Reset: assert rst low in WAIT with a buffered write pending → Stall=0 and DataMemOut=0 immediately; after release, a read of that address returns the old array value.
- LAT=3: reads of 0x0, 0x4, 0x8 back-to-back → Stall pattern 1,1,1,0 repeated three times with no extra bubble.
